// File: rtl/flag_int_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | flag_int_unit: C/Z flags with shadows, I flag, interrupt sync/latch    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module flag_int_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ALU_C,
  input  logic ALU_Z,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic FLG_C_LD,
  input  logic FLG_Z_LD,
  input  logic FLG_LD_SEL,
  input  logic FLG_SHAD_LD,
  input  logic I_SET,
  input  logic I_CLR,
  input  logic INT_ACK,
  input  logic INTR_IN,
  output logic C,
  output logic Z,
  output logic I_FLAG,
  output logic INT
);

  logic                   c_q, c_d;
  logic                   z_q, z_d;
  logic                   shad_c_q, shad_c_d;
  logic                   shad_z_q, shad_z_d;
  logic                   i_flag_q, i_flag_d;
  logic                   pending_q, pending_d;
  logic                   prev_q, prev_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_last;
  logic                   rise;

  always_comb begin
    c_d = c_q;
    if (FLG_C_SET)      c_d = 1'b1;
    else if (FLG_C_CLR) c_d = 1'b0;
    else if (FLG_C_LD)  c_d = FLG_LD_SEL ? shad_c_q : ALU_C;

    z_d = z_q;
    if (FLG_Z_LD) z_d = FLG_LD_SEL ? shad_z_q : ALU_Z;

    // Shadows capture the pre-edge flags, so a simultaneous restore swaps.
    shad_c_d = FLG_SHAD_LD ? c_q : shad_c_q;
    shad_z_d = FLG_SHAD_LD ? z_q : shad_z_q;

    i_flag_d = i_flag_q;
    if (I_CLR)      i_flag_d = 1'b0;
    else if (I_SET) i_flag_d = 1'b1;
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise      = sync_last & ~prev_q;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], INTR_IN};
    prev_d    = sync_last;
    // A new edge wins over the acknowledge so it is never dropped.
    pending_d = rise | (pending_q & ~INT_ACK);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      shad_c_q  <= 1'b0;
      shad_z_q  <= 1'b0;
      i_flag_q  <= 1'b0;
      pending_q <= 1'b0;
      prev_q    <= 1'b0;
      sync_q    <= '0;
    end else begin
      c_q       <= c_d;
      z_q       <= z_d;
      shad_c_q  <= shad_c_d;
      shad_z_q  <= shad_z_d;
      i_flag_q  <= i_flag_d;
      pending_q <= pending_d;
      prev_q    <= prev_d;
      sync_q    <= sync_d;
    end
  end

  assign C      = c_q;
  assign Z      = z_q;
  assign I_FLAG = i_flag_q;
  assign INT    = pending_q & i_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_int_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_flag_int_unit: directed + random checks against a behavioural model |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_flag_int_unit;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, alu_c, alu_z, c_set, c_clr, c_ld, z_ld, ld_sel, shad_ld;
  logic i_set, i_clr, int_ack, intr_in;
  logic c_o, z_o, i_o, int_o;

  flag_int_unit #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK(clk), .RESET(rst), .ALU_C(alu_c), .ALU_Z(alu_z),
    .FLG_C_SET(c_set), .FLG_C_CLR(c_clr), .FLG_C_LD(c_ld), .FLG_Z_LD(z_ld),
    .FLG_LD_SEL(ld_sel), .FLG_SHAD_LD(shad_ld), .I_SET(i_set), .I_CLR(i_clr),
    .INT_ACK(int_ack), .INTR_IN(intr_in),
    .C(c_o), .Z(z_o), .I_FLAG(i_o), .INT(int_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state; hist[k] is the INTR_IN value sampled k edges ago.
  bit m_c, m_z, m_sc, m_sz, m_i, m_pend;
  bit hist[$];

  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs;
    {rst, alu_c, alu_z, c_set, c_clr, c_ld, z_ld, ld_sel, shad_ld} = '0;
    {i_set, i_clr, int_ack, intr_in} = '0;
  endtask

  task automatic clear_ctrl;
    {rst, c_set, c_clr, c_ld, z_ld, ld_sel, shad_ld, i_set, i_clr, int_ack} = '0;
  endtask

  // Advance one edge in both DUT and model, then compare all outputs.
  task automatic tick;
    bit nc, nz, nsc, nsz, ni, np, rise;
    rise = hist[SYNC_STAGES-1] && !hist[SYNC_STAGES];
    nc = c_set ? 1'b1 : c_clr ? 1'b0 : c_ld ? (ld_sel ? m_sc : alu_c) : m_c;
    nz = z_ld ? (ld_sel ? m_sz : alu_z) : m_z;
    nsc = shad_ld ? m_c : m_sc;
    nsz = shad_ld ? m_z : m_sz;
    ni = i_clr ? 1'b0 : i_set ? 1'b1 : m_i;
    np = rise || (m_pend && !int_ack);
    @(posedge clk);
    if (rst) begin
      {m_c, m_z, m_sc, m_sz, m_i, m_pend} = '0;
      foreach (hist[k]) hist[k] = 1'b0;
    end else begin
      {m_c, m_z, m_sc, m_sz, m_i, m_pend} = {nc, nz, nsc, nsz, ni, np};
      hist.push_front(intr_in);
      void'(hist.pop_back());
    end
    #1;
    check("C", c_o, m_c);
    check("Z", z_o, m_z);
    check("I_FLAG", i_o, m_i);
    check("INT", int_o, m_pend & m_i);
  endtask

  initial begin
    for (int k = 0; k <= SYNC_STAGES; k++) hist.push_back(1'b0);
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset from a fully set state.
    c_set = 1; alu_z = 1; z_ld = 1; i_set = 1; intr_in = 1;
    tick();
    clear_ctrl();
    repeat (3) tick();
    check("pre_reset_int", int_o, 1'b1);
    rst = 1; intr_in = 0;
    tick();
    rst = 0;
    check("rst_c", c_o, 1'b0);
    check("rst_z", z_o, 1'b0);
    check("rst_i", i_o, 1'b0);
    check("rst_int", int_o, 1'b0);
    repeat (3) tick();

    // C priority.
    c_set = 1; c_clr = 1; c_ld = 1; alu_c = 0;
    tick();
    check("c_prio_set", c_o, 1'b1);
    c_set = 0; alu_c = 1;
    tick();
    check("c_prio_clr", c_o, 1'b0);
    clear_ctrl();

    // Build C=1, Z=0, shadow=(0,1), then swap.
    alu_z = 1; z_ld = 1; tick(); clear_ctrl();
    shad_ld = 1; tick(); clear_ctrl();
    c_set = 1; alu_z = 0; z_ld = 1; tick(); clear_ctrl();
    shad_ld = 1; c_ld = 1; z_ld = 1; ld_sel = 1;
    tick();
    check("swap_c", c_o, 1'b0);
    check("swap_z", z_o, 1'b1);
    clear_ctrl();
    c_ld = 1; z_ld = 1; ld_sel = 1;
    tick();
    check("swap_shad_c", c_o, 1'b1);
    check("swap_shad_z", z_o, 1'b0);
    clear_ctrl();

    // Latency with I set.
    i_set = 1; tick(); clear_ctrl();
    intr_in = 1;
    tick(); check("lat_n", int_o, 1'b0);
    tick(); check("lat_n1", int_o, 1'b0);
    tick(); check("lat_n2", int_o, 1'b1);
    int_ack = 1; tick(); clear_ctrl();
    check("ack_clears", int_o, 1'b0);
    repeat (3) tick();
    check("no_retrigger", int_o, 1'b0);

    // Masking.
    i_clr = 1; intr_in = 0; tick(); clear_ctrl();
    repeat (3) tick();
    intr_in = 1; repeat (3) tick();
    intr_in = 0; repeat (3) tick();
    check("masked", int_o, 1'b0);
    i_set = 1; tick(); clear_ctrl();
    check("unmask", int_o, 1'b1);
    i_set = 1; i_clr = 1; tick(); clear_ctrl();
    check("clr_wins", i_o, 1'b0);
    int_ack = 1; tick(); clear_ctrl();

    // Ack collision: rise coincides with INT_ACK.
    i_set = 1; intr_in = 1; tick(); clear_ctrl();
    repeat (2) tick();
    int_ack = 1; intr_in = 0; tick(); clear_ctrl();
    repeat (3) tick();
    intr_in = 1; tick(); tick();
    check("pend_before_collide", int_o, 1'b0);
    int_ack = 1; tick(); clear_ctrl();
    check("ack_collision", int_o, 1'b1);

    // Random phase.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      alu_c   = $urandom_range(0, 1);
      alu_z   = $urandom_range(0, 1);
      c_set   = ($urandom_range(0, 7) == 0);
      c_clr   = ($urandom_range(0, 7) == 0);
      c_ld    = ($urandom_range(0, 3) == 0);
      z_ld    = ($urandom_range(0, 3) == 0);
      ld_sel  = $urandom_range(0, 1);
      shad_ld = ($urandom_range(0, 3) == 0);
      i_set   = ($urandom_range(0, 5) == 0);
      i_clr   = ($urandom_range(0, 7) == 0);
      int_ack = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) intr_in = ~intr_in;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
